// File: rtl/seven_pkg.sv
// Shared constants for the 7-segment reader: segment bit positions, the 16 legal
// glyph patterns (bit0=a .. bit6=g, 1 = lit) and the frame FSM states.
package seven_pkg;

  localparam int SEG_IDX_A = 0;
  localparam int SEG_IDX_B = 1;
  localparam int SEG_IDX_C = 2;
  localparam int SEG_IDX_D = 3;
  localparam int SEG_IDX_E = 4;
  localparam int SEG_IDX_F = 5;
  localparam int SEG_IDX_G = 6;

  // One-hot masks per segment, so each glyph below reads as its list of lit segments.
  localparam logic [6:0] S_A = 7'(1) << SEG_IDX_A;
  localparam logic [6:0] S_B = 7'(1) << SEG_IDX_B;
  localparam logic [6:0] S_C = 7'(1) << SEG_IDX_C;
  localparam logic [6:0] S_D = 7'(1) << SEG_IDX_D;
  localparam logic [6:0] S_E = 7'(1) << SEG_IDX_E;
  localparam logic [6:0] S_F = 7'(1) << SEG_IDX_F;
  localparam logic [6:0] S_G = 7'(1) << SEG_IDX_G;

  localparam logic [6:0] SEG_0 = S_A | S_B | S_C | S_D | S_E | S_F;
  localparam logic [6:0] SEG_1 = S_B | S_C;
  localparam logic [6:0] SEG_2 = S_A | S_B | S_D | S_E | S_G;
  localparam logic [6:0] SEG_3 = S_A | S_B | S_C | S_D | S_G;
  localparam logic [6:0] SEG_4 = S_B | S_C | S_F | S_G;
  localparam logic [6:0] SEG_5 = S_A | S_C | S_D | S_F | S_G;
  localparam logic [6:0] SEG_6 = S_A | S_C | S_D | S_E | S_F | S_G;
  localparam logic [6:0] SEG_7 = S_A | S_B | S_C;
  localparam logic [6:0] SEG_8 = S_A | S_B | S_C | S_D | S_E | S_F | S_G;
  localparam logic [6:0] SEG_9 = S_A | S_B | S_C | S_D | S_F | S_G;
  localparam logic [6:0] SEG_A = S_A | S_B | S_C | S_E | S_F | S_G;
  localparam logic [6:0] SEG_B = S_C | S_D | S_E | S_F | S_G;
  localparam logic [6:0] SEG_C = S_D | S_E | S_G;
  localparam logic [6:0] SEG_D = S_B | S_C | S_D | S_E | S_G;
  localparam logic [6:0] SEG_E = S_A | S_D | S_E | S_F | S_G;
  localparam logic [6:0] SEG_F = S_A | S_E | S_F | S_G;

  typedef enum logic [0:0] {
    CAPTURE = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/seven_decode.sv
// Combinational glyph decoder: 7-bit segment pattern back to a hex nibble.
// Unknown patterns give nibble 0 with err_o set.
module seven_decode
  import seven_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    err_o    = 1'b0;
    case (pattern_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_reader.sv
// Recovers hex digits from a multiplexed active-high 7-segment bus and hands out
// whole frames over valid/ready. Optional partial-frame timeout: SEVEN_READER_TIMEOUT_EN.
module seven_reader
  import seven_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_digits,
  output logic [DIGITS-1:0]     out_err
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic [CNT_W-1:0]    stab_q, stab_d;
  logic                same_w, onehot_w, capture_w;
  logic [3:0]          dec_nibble;
  logic                dec_err;
  logic [DIGITS-1:0]   slot_we, mask_q, mask_d, mask_set;
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                valid_q, valid_d;
  logic                timeout_hit;
  state_e              state_q, state_d;

  assign same_w   = (an == an_q) && (seg == seg_q);
  assign onehot_w = (an != '0) && ((an & (an - DIGITS'(1))) == '0);

  // Fires only on the cycle the counter steps into saturation, so once per stable run.
  assign capture_w = same_w && onehot_w && (stab_q == CNT_W'(STABLE_CYCLES - 1));

  always_comb begin
    stab_d = '0;
    if (same_w && onehot_w) begin
      stab_d = (stab_q == CNT_W'(STABLE_CYCLES)) ? stab_q : stab_q + CNT_W'(1);
    end
  end

  seven_decode u_decode (
    .pattern_i (seg_q),
    .nibble_o  (dec_nibble),
    .err_o     (dec_err)
  );

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
      assign slot_we[gi]             = capture_w && (state_q == CAPTURE) && an_q[gi];
      assign digits_d[4*gi +: 4]     = slot_we[gi] ? dec_nibble : digits_q[4*gi +: 4];
      assign err_d[gi]               = slot_we[gi] ? dec_err : err_q[gi];
    end
  endgenerate

  assign mask_set = mask_q | slot_we;

`ifdef SEVEN_READER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_q, to_d;

  // Counts idle cycles of a partial frame; any capture restarts the wait.
  always_comb begin
    to_d        = '0;
    timeout_hit = 1'b0;
    if ((state_q == CAPTURE) && (mask_q != '0) && (slot_we == '0)) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  // Partial frames wait indefinitely; only a degenerate zero timeout would drop them.
  assign timeout_hit = (TIMEOUT_CYCLES < 1);
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    mask_d  = mask_q;
    case (state_q)
      CAPTURE: begin
        if (timeout_hit) begin
          mask_d = '0;
        end else begin
          mask_d = mask_set;
          if (&mask_set) begin
            state_d = PRESENT;
            valid_d = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          mask_d  = '0;
          state_d = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= '0;
      seg_q    <= '0;
      stab_q   <= '0;
      mask_q   <= '0;
      digits_q <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      state_q  <= CAPTURE;
    end else begin
      an_q     <= an;
      seg_q    <= seg;
      stab_q   <= stab_d;
      mask_q   <= mask_d;
      digits_q <= digits_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_digits = digits_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_seven_reader.sv
// Bench for seven_reader: directed frame table, reset/backpressure sequences,
// randomized traffic against a run-length reference model; timeout part under SEVEN_READER_TIMEOUT_EN.
module tb_seven_reader;

  localparam int DIGITS  = 4;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  an = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_digits;
  logic [3:0]  out_err;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int cycle = 0;

  seven_reader #(
    .DIGITS         (DIGITS),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .an         (an),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // Glyph table written straight from the decode list, MSB = g.
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'b0111111; glyph[1]  = 7'b0000110; glyph[2]  = 7'b1011011; glyph[3]  = 7'b1001111;
    glyph[4]  = 7'b1100110; glyph[5]  = 7'b1101101; glyph[6]  = 7'b1111101; glyph[7]  = 7'b0000111;
    glyph[8]  = 7'b1111111; glyph[9]  = 7'b1101111; glyph[10] = 7'b1110111; glyph[11] = 7'b1111100;
    glyph[12] = 7'b1011000; glyph[13] = 7'b1011110; glyph[14] = 7'b1111001; glyph[15] = 7'b1110001;
  end

  // Reference model: run length of the sampled {an,seg}, slots, presence bits, valid flag.
  logic [10:0] m_prev;
  int          m_run;
  logic [15:0] m_dig;
  logic [3:0]  m_err;
  logic [3:0]  m_have;
  logic        m_valid;
  int          m_idle;

  function automatic void model_reset();
    m_prev = '0; m_run = 0; m_dig = '0; m_err = '0; m_have = '0; m_valid = 1'b0; m_idle = 0;
  endfunction

  function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n, output logic e);
    n = 4'h0; e = 1'b1;
    for (int i = 0; i < 16; i++) if (glyph[i] == p) begin n = 4'(i); e = 1'b0; end
  endfunction

  function automatic void model_edge(input logic [3:0] a, input logic [6:0] s, input logic r);
    logic [3:0] n;
    logic e;
    logic cap;
    if ({a, s} == m_prev) m_run++; else m_run = 1;
    m_prev = {a, s};
    // A value seen at STABLE+1 consecutive edges has been equal STABLE times in a row.
    cap = ($countones(a) == 1) && (m_run == STABLE + 1);
    if (m_valid) begin
      m_idle = 0;
      if (r) begin m_valid = 1'b0; m_have = '0; end
    end else if (cap) begin
      ref_decode(s, n, e);
      for (int k = 0; k < DIGITS; k++) if (a[k]) begin
        m_dig[4*k +: 4] = n; m_err[k] = e; m_have[k] = 1'b1;
      end
      m_idle = 0;
      if (m_have == 4'hF) m_valid = 1'b1;
    end else if (m_have != '0) begin
      m_idle++;
`ifdef SEVEN_READER_TIMEOUT_EN
      if (m_idle == TIMEOUT) begin m_have = '0; m_idle = 0; end
`endif
    end else begin
      m_idle = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic r);
    an = a; seg = s; out_ready = r;
    @(posedge clk);
    cycle++;
    model_edge(a, s, r);
    #1;
    if (out_valid === 1'b1) pulses++;
    vectors++;
    if (out_valid !== m_valid || out_digits !== m_dig || out_err !== m_err) begin
      miscompares++;
      $display("FAIL model cycle %0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
               cycle, out_valid, out_digits, out_err, m_valid, m_dig, m_err);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic r, input int n);
    pulses = 0;
    repeat (n) step(a, s, r);
  endtask

  // Called at posedge+1; asserts reset mid-cycle, checks async clear, releases at posedge+1.
  task automatic do_reset(input string name);
    an = '0; seg = '0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk({name, " valid"}, 32'(out_valid), 32'h0);
    chk({name, " digits"}, 32'(out_digits), 32'h0);
    chk({name, " err"}, 32'(out_err), 32'h0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rdy;
    int          cycles;
    logic        exp_valid;
    logic [15:0] exp_dig;
    logic [3:0]  exp_err;
    int          exp_pulses;
  } rec_t;

  rec_t tbl [27];

  function automatic rec_t mk(input logic [3:0] a, input logic [6:0] s, input logic r, input int c,
                              input logic v, input logic [15:0] d, input logic [3:0] e, input int p);
    rec_t x;
    x.an = a; x.seg = s; x.rdy = r; x.cycles = c;
    x.exp_valid = v; x.exp_dig = d; x.exp_err = e; x.exp_pulses = p;
    return x;
  endfunction

  initial begin
    logic [3:0] ra;
    logic [6:0] rs;
    int         n;

    model_reset();
    // Clean frame E1A3 with out_ready high: single-cycle valid pulse.
    tbl[0]  = mk(4'b0001, 7'b1001111, 1'b1, 8, 1'b0, 16'h0003, 4'b0000, 0);
    tbl[1]  = mk(4'b0010, 7'b1110111, 1'b1, 8, 1'b0, 16'h00A3, 4'b0000, 0);
    tbl[2]  = mk(4'b0100, 7'b0000110, 1'b1, 8, 1'b0, 16'h01A3, 4'b0000, 0);
    tbl[3]  = mk(4'b1000, 7'b1111001, 1'b1, 8, 1'b0, 16'hE1A3, 4'b0000, 1);
    // Glitching digit 0 and a multi-hot enable never capture.
    tbl[4]  = mk(4'b0001, 7'b0111111, 1'b1, 2, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[5]  = mk(4'b0001, 7'b0111110, 1'b1, 2, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[6]  = mk(4'b0001, 7'b0111111, 1'b1, 2, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[7]  = mk(4'b0001, 7'b0111110, 1'b1, 2, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[8]  = mk(4'b0001, 7'b0111111, 1'b1, 2, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[9]  = mk(4'b0001, 7'b0111110, 1'b1, 2, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[10] = mk(4'b0011, 7'b1111111, 1'b1, 10, 1'b0, 16'hE1A3, 4'b0000, 0);
    tbl[11] = mk(4'b0010, 7'b1100110, 1'b1, 8, 1'b0, 16'hE143, 4'b0000, 0);
    tbl[12] = mk(4'b0100, 7'b1011011, 1'b1, 8, 1'b0, 16'hE243, 4'b0000, 0);
    tbl[13] = mk(4'b1000, 7'b1111101, 1'b1, 8, 1'b0, 16'h6243, 4'b0000, 0);
    tbl[14] = mk(4'b0001, 7'b0111111, 1'b1, 8, 1'b0, 16'h6240, 4'b0000, 1);
    // Illegal glyph in digit 2.
    tbl[15] = mk(4'b0001, 7'b1101101, 1'b1, 8, 1'b0, 16'h6245, 4'b0000, 0);
    tbl[16] = mk(4'b0010, 7'b0000111, 1'b1, 8, 1'b0, 16'h6275, 4'b0000, 0);
    tbl[17] = mk(4'b0100, 7'b0101010, 1'b1, 8, 1'b0, 16'h6075, 4'b0100, 0);
    tbl[18] = mk(4'b1000, 7'b1011000, 1'b1, 8, 1'b0, 16'hC075, 4'b0100, 1);
    // Backpressure: frame held through 20 cycles of new digits, then one handshake.
    tbl[19] = mk(4'b0001, 7'b1111111, 1'b0, 8, 1'b0, 16'hC078, 4'b0100, 0);
    tbl[20] = mk(4'b0010, 7'b1101111, 1'b0, 8, 1'b0, 16'hC098, 4'b0100, 0);
    tbl[21] = mk(4'b0100, 7'b1111100, 1'b0, 8, 1'b0, 16'hCB98, 4'b0000, 0);
    tbl[22] = mk(4'b1000, 7'b1011110, 1'b0, 8, 1'b1, 16'hDB98, 4'b0000, 4);
    tbl[23] = mk(4'b0001, 7'b1110001, 1'b0, 10, 1'b1, 16'hDB98, 4'b0000, 10);
    tbl[24] = mk(4'b0010, 7'b1111101, 1'b0, 10, 1'b1, 16'hDB98, 4'b0000, 10);
    tbl[25] = mk(4'b0010, 7'b1111101, 1'b1, 1, 1'b0, 16'hDB98, 4'b0000, 0);
    tbl[26] = mk(4'b0010, 7'b1111101, 1'b1, 6, 1'b0, 16'hDB98, 4'b0000, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(out_valid), 32'h0);
    chk("reset digits", 32'(out_digits), 32'h0);
    chk("reset err", 32'(out_err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 27; i++) begin
      hold(tbl[i].an, tbl[i].seg, tbl[i].rdy, tbl[i].cycles);
      chk($sformatf("tbl%0d valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d digits", i), 32'(out_digits), 32'(tbl[i].exp_dig));
      chk($sformatf("tbl%0d err", i), 32'(out_err), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d pulses", i), 32'(pulses), 32'(tbl[i].exp_pulses));
    end

    // Reset mid-frame drops the partial frame: all four digits needed again.
    hold(4'b0001, 7'b0000110, 1'b1, 8);
    hold(4'b0010, 7'b1011011, 1'b1, 8);
    chk("partial digits", 32'(out_digits), 32'hDB21);
    do_reset("midreset");
    hold(4'b0010, 7'b1001111, 1'b1, 8);
    hold(4'b0100, 7'b1100110, 1'b1, 8);
    hold(4'b1000, 7'b1101101, 1'b1, 8);
    chk("after reset no frame", 32'(pulses), 32'h0);
    chk("after reset digits", 32'(out_digits), 32'h5430);
    hold(4'b0001, 7'b1111101, 1'b1, 8);
    chk("after reset frame pulse", 32'(pulses), 32'h1);
    chk("after reset frame digits", 32'(out_digits), 32'h5436);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(1, 8);
      case ($urandom_range(0, 9))
        0:       ra = 4'b0000;
        1:       ra = 4'($urandom_range(0, 15)) | 4'b0101;
        default: ra = 4'b0001 << $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 9) == 0) rs = 7'($urandom_range(0, 127));
      else begin rs = glyph[$urandom_range(0, 15)]; end
      for (int j = 0; j < n; j++) step(ra, rs, 1'($urandom_range(0, 1)));
    end

`ifdef SEVEN_READER_TIMEOUT_EN
    do_reset("toreset");
    hold(4'b0001, 7'b0000110, 1'b1, 8);
    hold(4'b0010, 7'b1011011, 1'b1, 8);
    hold(4'b0000, 7'b0000000, 1'b1, 60);
    hold(4'b0100, 7'b1001111, 1'b1, 8);
    pulses = 0;
    hold(4'b1000, 7'b1100110, 1'b1, 8);
    chk("timeout no frame", 32'(pulses), 32'h0);
    chk("timeout valid", 32'(out_valid), 32'h0);
    chk("timeout digits kept", 32'(out_digits), 32'h4321);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_reader.md
Name: seven_reader

Overview:
- Reads a multiplexed, active-high 7-segment display bus and recovers the hex digits being shown.
- Each digit's segment pattern is filtered for stability, then decoded back to a nibble and assembled into a frame.
- The frame is handed off over a valid/ready interface.
- It is the receive-side inverse of the team's nibble-to-segment encoder, used in self-check and loop-back of display paths.

Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4, consecutive identical cycles required before a digit is captured (>=1).
- TIMEOUT_CYCLES, 1000000, partial-frame timeout; used only under SEVEN_READER_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg  in  7  segment lines, bit0=a .. bit6=g, 1 = lit.
- an  in  DIGITS  digit enables, one-hot, 1 = digit active; an[k] selects digit k.
- out_ready  in  1  consumer accepts frame.
- out_valid  out  1  frame available.
- out_digits  out  4*DIGITS  decoded nibbles; digit k at bits [4k+3:4k].
- out_err  out  DIGITS  1 = digit k pattern was not a legal glyph.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_digits=0, out_err=0, capture mask=0, stability counter=0, state=CAPTURE.
- Decode table, pattern -> nibble, 16 legal glyphs:
  - 0111111->0, 0000110->1, 1011011->2, 1001111->3
  - 1100110->4, 1101101->5, 1111101->6, 0000111->7
  - 1111111->8, 1101111->9, 1110111->A, 1111100->B
  - 1011000->C, 1011110->D, 1111001->E, 1110001->F
  - Any other pattern decodes to nibble 0 with the err bit set.
- Stability filter:
  - Register {an, seg} each cycle.
  - If the current value equals the previous one and an is one-hot, increment the counter, saturating at STABLE_CYCLES.
  - Otherwise clear the counter to 0.
  - an all-zero or multi-hot never captures.
- Capture: when the counter reaches STABLE_CYCLES, occurring exactly once per stable run, write the decoded nibble and err bit into slot k and set mask[k].
  - Capture occurs STABLE_CYCLES cycles after the first cycle of the stable value.
  - Re-capture of an already-set slot in the same frame overwrites it.
- States:
  - CAPTURE: collect digits. When the mask becomes all-ones, go to PRESENT and assert out_valid on the next cycle.
  - PRESENT: outputs held constant; seg/an are still filtered but captures are discarded.
  - On out_valid && out_ready: deassert out_valid, clear the mask, return to CAPTURE.
  - out_digits/out_err keep their last values until overwritten.
- out_valid never drops without a handshake.
- out_ready is ignored while out_valid=0.
- A capture completing a frame in the same cycle as a handshake cannot occur: state is PRESENT.
- Reset mid-frame discards the partial frame and the pending output.

Optional Feature:
- Macro: SEVEN_READER_TIMEOUT_EN.
- Defined:
  - In CAPTURE with a nonzero mask, a counter increments each cycle and resets on every capture.
  - On reaching TIMEOUT_CYCLES, the mask is cleared (partial frame dropped) and the counter is zeroed. out_* are unaffected.
  - Inactive in PRESENT.
- Undefined: partial frames wait indefinitely; no counter logic is synthesized.

Decomposition:
- Package seven_pkg:
  - the 16 segment-pattern constants (SEG_0..SEG_F);
  - the segment bit-index constants;
  - the state enum {CAPTURE, PRESENT}.
- One combinational sub-module, seven_decode: 7-bit pattern in, 4-bit nibble out plus err. It is instantiated once on the filtered seg.

Test Plan:
- Reset: rst_n=0 mid-frame, then 1 -> out_valid=0, out_digits=0, out_err=0; next frame needs all DIGITS captures.
- Clean frame, DIGITS=4, STABLE_CYCLES=4:
  - drive an=0001 seg=1001111 (8 cycles), an=0010 seg=1110111, an=0100 seg=0000110, an=1000 seg=1111001, out_ready=1;
  - expect out_digits=16'hE1A3, out_err=0, one-cycle out_valid pulse.
- Glitch rejection:
  - an=0001 with seg toggling between 0111111 and 0111110 every 2 cycles -> no capture, mask stays 0;
  - an=0011 held 10 cycles -> no capture.
- Illegal glyph: digit 2 seg=0101010 stable, others legal -> out_err=4'b0100, nibble 2 = 0.
- Backpressure:
  - complete frame, out_ready=0 for 20 cycles while driving new legal digits -> out_valid and out_digits unchanged;
  - raise out_ready -> handshake in 1 cycle, then fresh capture needed.
- Timeout (with SEVEN_READER_TIMEOUT_EN, TIMEOUT_CYCLES=50):
  - capture digits 0 and 1, idle 50 cycles -> mask cleared;
  - then digits 2 and 3 only -> no out_valid.
